// File: rtl/mem_arbiter.sv
// Two-port arbiter for the LC-3 single synchronous memory port: CPU has priority,
// a starvation counter guarantees DMA forward progress.
//
// state | meaning
// IDLE  | sample requests, grant and latch the winning request
// ISSUE | mem_en strobe for exactly one cycle
// WAIT  | MEM_LAT cycles of read latency, capture read data on the last one
// DONE  | one-cycle ready pulse to the owner
module mem_arbiter #(
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic        cpu_ready,
   output logic [15:0] cpu_rdata,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [15:0] dma_addr,
   input  logic [15:0] dma_wdata,
   output logic        dma_ready,
   output logic [15:0] dma_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic        busy,
   output logic        owner
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t      state_q, state_d;
   logic [2:0]  wait_q, wait_d;
   logic [3:0]  starve_q, starve_d;
   logic        owner_q, owner_d;
   logic        we_q, we_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] cpu_rdata_q, cpu_rdata_d;
   logic [15:0] dma_rdata_q, dma_rdata_d;
   logic        grant_dma;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         wait_q      <= 3'd0;
         starve_q    <= 4'd0;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= 16'h0000;
         wdata_q     <= 16'h0000;
         cpu_rdata_q <= 16'h0000;
         dma_rdata_q <= 16'h0000;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         starve_q    <= starve_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      starve_d    = starve_q;
      owner_d     = owner_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;
      grant_dma   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cpu_req || dma_req) begin
               // DMA only beats a waiting CPU once it has lost STARVE_MAX times in a row
               grant_dma = dma_req && (!cpu_req || (starve_q == STARVE_LIM));
               owner_d   = grant_dma;
               we_d      = grant_dma ? dma_we    : cpu_we;
               addr_d    = grant_dma ? dma_addr  : cpu_addr;
               wdata_d   = grant_dma ? dma_wdata : cpu_wdata;
               state_d   = S_ISSUE;
               if (grant_dma) begin
                  starve_d = 4'd0;
               end else if (dma_req && (starve_q != STARVE_LIM)) begin
                  starve_d = starve_q + 4'd1;
               end
            end
         end
         S_ISSUE: begin
            wait_d  = LAT_LOAD;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (wait_q == 3'd0) begin
               state_d = S_DONE;
               if (!we_q) begin
                  if (owner_q) begin
                     dma_rdata_d = mem_rdata;
                  end else begin
                     cpu_rdata_d = mem_rdata;
                  end
               end
            end else begin
               wait_d = wait_q - 3'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign mem_en    = (state_q == S_ISSUE);
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign cpu_ready = (state_q == S_DONE) && !owner_q;
   assign dma_ready = (state_q == S_DONE) &&  owner_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dma_rdata = dma_rdata_q;
   assign busy      = (state_q != S_IDLE);
   assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 uses MEM_LAT=1/STARVE_MAX=4, instance 1 MEM_LAT=3/STARVE_MAX=1.
// Expected grants are queued as requests are made; a negedge monitor retires them against the DUT.
module tb_mem_arbiter;

   typedef struct {
      bit          port;
      bit          we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst       [2];
   logic        cpu_req   [2];
   logic        cpu_we    [2];
   logic [15:0] cpu_addr  [2];
   logic [15:0] cpu_wdata [2];
   logic        cpu_ready [2];
   logic [15:0] cpu_rdata [2];
   logic        dma_req   [2];
   logic        dma_we    [2];
   logic [15:0] dma_addr  [2];
   logic [15:0] dma_wdata [2];
   logic        dma_ready [2];
   logic [15:0] dma_rdata [2];
   logic        mem_en    [2];
   logic        mem_we    [2];
   logic [15:0] mem_addr  [2];
   logic [15:0] mem_wdata [2];
   logic [15:0] mem_rdata [2];
   logic        busy      [2];
   logic        owner     [2];

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   exp_t        exp_q [2][$];
   bit          issued  [2];
   int          iss_cyc [2];
   logic [15:0] sh_rd   [2][2];
   int          rd_cnt  [2];
   logic [15:0] rd_dat  [2];
   logic [15:0] mem_img [logic [16:0]];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut0 (
      .clk(clk), .reset(rst[0]),
      .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
      .cpu_ready(cpu_ready[0]), .cpu_rdata(cpu_rdata[0]),
      .dma_req(dma_req[0]), .dma_we(dma_we[0]), .dma_addr(dma_addr[0]), .dma_wdata(dma_wdata[0]),
      .dma_ready(dma_ready[0]), .dma_rdata(dma_rdata[0]),
      .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
      .mem_rdata(mem_rdata[0]), .busy(busy[0]), .owner(owner[0]));

   mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(1)) u_dut1 (
      .clk(clk), .reset(rst[1]),
      .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
      .cpu_ready(cpu_ready[1]), .cpu_rdata(cpu_rdata[1]),
      .dma_req(dma_req[1]), .dma_we(dma_we[1]), .dma_addr(dma_addr[1]), .dma_wdata(dma_wdata[1]),
      .dma_ready(dma_ready[1]), .dma_rdata(dma_rdata[1]),
      .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
      .mem_rdata(mem_rdata[1]), .busy(busy[1]), .owner(owner[1]));

   function automatic int lat(int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic logic [15:0] mem_rd(int i, logic [15:0] a);
      logic [16:0] key;
      key = {i[0], a};
      if (mem_img.exists(key)) return mem_img[key];
      if (i == 0 && a == 16'h1000) return 16'hBEEF;
      return a ^ 16'h5A5A;
   endfunction

   function automatic exp_t mk(int i, bit port, bit we, logic [15:0] a, logic [15:0] wd);
      exp_t e;
      e.port  = port;
      e.we    = we;
      e.addr  = a;
      e.wdata = wd;
      e.rdata = we ? 16'h0000 : mem_rd(i, a);
      return e;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(int i, bit port);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         tick(1);
         seen = port ? dma_ready[i] : cpu_ready[i];
      end
      chk("ready_seen", {31'd0, seen}, 32'd1);
   endtask

   task automatic drive(int i, bit port, bit we, logic [15:0] a, logic [15:0] wd);
      if (port) begin
         dma_we[i] = we; dma_addr[i] = a; dma_wdata[i] = wd; dma_req[i] = 1'b1;
      end else begin
         cpu_we[i] = we; cpu_addr[i] = a; cpu_wdata[i] = wd; cpu_req[i] = 1'b1;
      end
   endtask

   task automatic do_req(int i, bit port, bit we, logic [15:0] a, logic [15:0] wd);
      exp_q[i].push_back(mk(i, port, we, a, wd));
      drive(i, port, we, a, wd);
      wait_ready(i, port);
      if (port) dma_req[i] = 1'b0;
      else      cpu_req[i] = 1'b0;
   endtask

   // Monitor and memory model: memory data is valid only in the cycle MEM_LAT after mem_en.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         exp_t e;
         if (rst[i]) begin
            if (issued[i] && exp_q[i].size() > 0) e = exp_q[i].pop_front();
            issued[i] = 1'b0;
            sh_rd[i][0] = 16'h0000;
            sh_rd[i][1] = 16'h0000;
         end else begin
            if (mem_en[i]) begin
               chk("mem_en_expected", {31'd0, (exp_q[i].size() > 0) && !issued[i]}, 32'd1);
               if (exp_q[i].size() > 0 && !issued[i]) begin
                  e = exp_q[i][0];
                  chk("mem_we",    {31'd0, mem_we[i]}, {31'd0, e.we});
                  chk("mem_addr",  {16'd0, mem_addr[i]}, {16'd0, e.addr});
                  chk("mem_wdata", {16'd0, mem_wdata[i]}, {16'd0, e.wdata});
                  chk("owner",     {31'd0, owner[i]}, {31'd0, e.port});
                  issued[i]  = 1'b1;
                  iss_cyc[i] = cyc;
               end
               if (mem_we[i]) mem_img[{i[0], mem_addr[i]}] = mem_wdata[i];
            end
            if (cpu_ready[i] || dma_ready[i]) begin
               chk("ready_exclusive", {31'd0, cpu_ready[i] & dma_ready[i]}, 32'd0);
               chk("ready_expected", {31'd0, issued[i] && (exp_q[i].size() > 0)}, 32'd1);
               if (issued[i] && exp_q[i].size() > 0) begin
                  e = exp_q[i].pop_front();
                  chk("ready_port", {31'd0, dma_ready[i]}, {31'd0, e.port});
                  chk("ready_latency", 32'(cyc - iss_cyc[i]), 32'(lat(i) + 1));
                  if (!e.we) sh_rd[i][e.port] = e.rdata;
                  chk("cpu_rdata", {16'd0, cpu_rdata[i]}, {16'd0, sh_rd[i][0]});
                  chk("dma_rdata", {16'd0, dma_rdata[i]}, {16'd0, sh_rd[i][1]});
                  issued[i] = 1'b0;
               end
            end
         end
         mem_rdata[i] = 16'hDEAD;
         if (rd_cnt[i] > 0) begin
            rd_cnt[i]--;
            if (rd_cnt[i] == 0) mem_rdata[i] = rd_dat[i];
         end
         if (mem_en[i] && !mem_we[i]) begin
            rd_cnt[i] = lat(i);
            rd_dat[i] = mem_rd(i, mem_addr[i]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1;
         cpu_req[i] = 1'b0; cpu_we[i] = 1'b0; cpu_addr[i] = 16'h0; cpu_wdata[i] = 16'h0;
         dma_req[i] = 1'b0; dma_we[i] = 1'b0; dma_addr[i] = 16'h0; dma_wdata[i] = 16'h0;
         issued[i] = 1'b0; rd_cnt[i] = 0; rd_dat[i] = 16'h0;
         sh_rd[i][0] = 16'h0; sh_rd[i][1] = 16'h0;
      end
      tick(2);
      for (int i = 0; i < 2; i++) begin
         chk("rst_ctrl", {26'd0, mem_en[i], mem_we[i], busy[i], owner[i], cpu_ready[i], dma_ready[i]}, 32'd0);
         chk("rst_addr_wdata", {mem_addr[i], mem_wdata[i]}, 32'd0);
         chk("rst_rdata", {cpu_rdata[i], dma_rdata[i]}, 32'd0);
         rst[i] = 1'b0;
      end
      tick(1);

      // CPU read, MEM_LAT=1: mem_en at T+1, ready at T+3
      exp_q[0].push_back(mk(0, 1'b0, 1'b0, 16'h1000, 16'h7777));
      drive(0, 1'b0, 1'b0, 16'h1000, 16'h7777);
      tick(1);
      chk("t1_mem_en", {31'd0, mem_en[0]}, 32'd1);
      chk("t1_mem_addr", {16'd0, mem_addr[0]}, 32'h1000);
      tick(1);
      chk("t1_en_ready_t2", {30'd0, mem_en[0], cpu_ready[0]}, 32'd0);
      tick(1);
      chk("t1_cpu_ready", {31'd0, cpu_ready[0]}, 32'd1);
      chk("t1_rdata", {cpu_rdata[0], dma_rdata[0]}, 32'hBEEF_0000);
      cpu_req[0] = 1'b0;
      tick(1);
      chk("t1_after", {30'd0, cpu_ready[0], busy[0]}, 32'd0);

      // Idle hold
      for (int k = 0; k < 20; k++) begin
         tick(1);
         chk("idle_hold", {28'd0, mem_en[0], busy[0], cpu_ready[0], dma_ready[0]}, 32'd0);
      end

      // Input changes after grant are ignored, dropped req still completes
      exp_q[0].push_back(mk(0, 1'b0, 1'b0, 16'h0040, 16'h7777));
      drive(0, 1'b0, 1'b0, 16'h0040, 16'h7777);
      tick(2);
      cpu_addr[0] = 16'hFFFF;
      cpu_req[0]  = 1'b0;
      chk("chg_mem_addr", {16'd0, mem_addr[0]}, 32'h0040);
      wait_ready(0, 1'b0);
      chk("chg_mem_addr_done", {16'd0, mem_addr[0]}, 32'h0040);
      tick(4);
      chk("chg_no_extra", {31'd0, busy[0]}, 32'd0);

      // Contention with STARVE_MAX=4: CPU x4, DMA, CPU x4, DMA
      for (int k = 0; k < 4; k++) exp_q[0].push_back(mk(0, 1'b0, 1'b0, 16'h0100 + 16'(k), 16'h7777));
      exp_q[0].push_back(mk(0, 1'b1, 1'b0, 16'h3100, 16'h0D0D));
      for (int k = 4; k < 8; k++) exp_q[0].push_back(mk(0, 1'b0, 1'b0, 16'h0100 + 16'(k), 16'h7777));
      exp_q[0].push_back(mk(0, 1'b1, 1'b0, 16'h3101, 16'h0D0D));
      dma_we[0] = 1'b0;
      dma_wdata[0] = 16'h0D0D;
      fork
         begin
            for (int k = 0; k < 8; k++) begin
               cpu_addr[0] = 16'h0100 + 16'(k);
               cpu_req[0]  = 1'b1;
               wait_ready(0, 1'b0);
            end
            cpu_req[0] = 1'b0;
         end
         begin
            for (int k = 0; k < 2; k++) begin
               dma_addr[0] = 16'h3100 + 16'(k);
               dma_req[0]  = 1'b1;
               wait_ready(0, 1'b1);
            end
            dma_req[0] = 1'b0;
         end
      join
      tick(3);
      chk("cont_drained", 32'(exp_q[0].size()), 32'd0);

      // Instance 1 (MEM_LAT=3): read first so the later checks see a non-zero cpu_rdata
      do_req(1, 1'b0, 1'b0, 16'h2000, 16'h0000);
      tick(1);

      // DMA write: ready at T+5, rdata registers untouched
      exp_q[1].push_back(mk(1, 1'b1, 1'b1, 16'h3000, 16'h1234));
      drive(1, 1'b1, 1'b1, 16'h3000, 16'h1234);
      tick(1);
      chk("w_mem_en_we", {30'd0, mem_en[1], mem_we[1]}, 32'd3);
      chk("w_addr_data", {mem_addr[1], mem_wdata[1]}, 32'h3000_1234);
      tick(1);
      chk("w_mem_en_off", {31'd0, mem_en[1]}, 32'd0);
      tick(2);
      chk("w_no_early_ready", {31'd0, dma_ready[1]}, 32'd0);
      tick(1);
      chk("w_dma_ready", {31'd0, dma_ready[1]}, 32'd1);
      chk("w_rdata_kept", {cpu_rdata[1], dma_rdata[1]}, 32'h7A5A_0000);
      dma_req[1] = 1'b0;
      dma_we[1]  = 1'b0;
      tick(1);

      // Reset during WAIT of a DMA read
      exp_q[1].push_back(mk(1, 1'b1, 1'b0, 16'h2222, 16'h4444));
      drive(1, 1'b1, 1'b0, 16'h2222, 16'h4444);
      tick(2);
      chk("r_in_wait", {30'd0, busy[1], mem_en[1]}, 32'd2);
      rst[1]     = 1'b1;
      dma_req[1] = 1'b0;
      tick(1);
      rst[1] = 1'b0;
      chk("r_ctrl", {26'd0, mem_en[1], mem_we[1], busy[1], owner[1], cpu_ready[1], dma_ready[1]}, 32'd0);
      chk("r_addr_wdata", {mem_addr[1], mem_wdata[1]}, 32'd0);
      chk("r_rdata", {cpu_rdata[1], dma_rdata[1]}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick(1);
         chk("r_no_ready", {30'd0, cpu_ready[1], dma_ready[1]}, 32'd0);
      end
      do_req(1, 1'b1, 1'b0, 16'h3000, 16'h0000);
      tick(1);

      // STARVE_MAX=1: strict alternation
      for (int k = 0; k < 3; k++) begin
         exp_q[1].push_back(mk(1, 1'b0, 1'b0, 16'h0200 + 16'(k), 16'h0000));
         exp_q[1].push_back(mk(1, 1'b1, 1'b0, 16'h3200 + 16'(k), 16'h0000));
      end
      cpu_wdata[1] = 16'h0000;
      dma_wdata[1] = 16'h0000;
      fork
         begin
            for (int k = 0; k < 3; k++) begin
               cpu_addr[1] = 16'h0200 + 16'(k);
               cpu_req[1]  = 1'b1;
               wait_ready(1, 1'b0);
            end
            cpu_req[1] = 1'b0;
         end
         begin
            for (int k = 0; k < 3; k++) begin
               dma_addr[1] = 16'h3200 + 16'(k);
               dma_req[1]  = 1'b1;
               wait_ready(1, 1'b1);
            end
            dma_req[1] = 1'b0;
         end
      join
      tick(3);
      chk("alt_drained", 32'(exp_q[1].size()), 32'd0);
      chk("final_idle", {30'd0, busy[0], busy[1]}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the LC-3's single synchronous memory port between two requesters: the CPU (microcontroller MAR/MDR path, port 0) and a DMA/debug engine (port 1). Each port uses a req/ready handshake. The arbiter registers the winning request, issues exactly one memory cycle, and waits a fixed read latency. It then returns read data with a one-cycle ready pulse. The CPU has priority, and a starvation counter guarantees the DMA port forward progress.

## Interface
- MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..7
- STARVE_MAX, 4, number of consecutive lost arbitrations after which DMA wins; legal range 1..15
- clk  in  1  system clock, all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request, held until cpu_ready
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  16  CPU address
- cpu_wdata  in  16  CPU write data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  16  registered read data, valid from the cpu_ready cycle until the next CPU read completes
- dma_req, dma_we, dma_addr, dma_wdata, dma_ready, dma_rdata: same as the cpu_* signals, for port 1
- mem_en  out  1  memory strobe, high exactly one cycle per transaction
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  16  latched address
- mem_wdata  out  16  latched write data
- mem_rdata  in  16  memory read data
- busy  out  1  high in every state except IDLE
- owner  out  1  port of the current or last transaction (0 = CPU, 1 = DMA)

## Operation
- FSM states: IDLE → ISSUE → WAIT → DONE → IDLE.
- IDLE:
  - Sample requests. Only one port requesting: grant it.
  - Both ports requesting: grant the CPU, unless starve_cnt == STARVE_MAX, in which case grant DMA.
  - On grant, latch we/addr/wdata into mem_we/mem_addr/mem_wdata, set owner, and go to ISSUE.
  - No request: stay in IDLE.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_MAX) on each IDLE grant where dma_req is high and the CPU wins.
  - It clears on any DMA grant.
  - It is unchanged otherwise.
- ISSUE (1 cycle): mem_en = 1, mem_we = latched we.
- WAIT (MEM_LAT cycles):
  - mem_en = 0.
  - A down-counter loaded with MEM_LAT-1 on entry; exit to DONE when it is 0.
  - On the final WAIT cycle, a read captures mem_rdata into the owner's rdata register. A write leaves both rdata registers unchanged.
- DONE (1 cycle): the owner's ready is high, then go to IDLE.
- Handshake rules:
  - Requester inputs are sampled only in IDLE. Changes to addr/wdata/we after the grant are ignored.
  - A req dropped after the grant does not cancel the transaction; ready still pulses.
  - A req still high in the IDLE cycle after DONE is treated as a new request. Requesters deassert on seeing ready.
- mem_addr, mem_wdata and mem_we hold their values from grant until the next grant.

## Timing
- Request seen in IDLE at cycle T:
  - mem_en at T+1.
  - Read capture at the end of T+1+MEM_LAT.
  - ready pulse at T+2+MEM_LAT.
  - Back in IDLE at T+3+MEM_LAT.
- With MEM_LAT=1, ready is at T+3 and a transaction occurs at most every 4 cycles.
- Back-to-back requests get no IDLE bypass: there is always one IDLE cycle between DONE and the next ISSUE.
- Reset values:
  - state IDLE, starve_cnt 0.
  - mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0.
  - cpu_ready 0, dma_ready 0, cpu_rdata 0, dma_rdata 0.
  - busy 0, owner 0.
- Reset mid-transaction in any state:
  - Return to IDLE on the next edge with no ready pulse.
  - A memory cycle already strobed is not retracted, and its read data is discarded.
- ready is never high for both ports in the same cycle, and never for more than one cycle per grant.
- STARVE_MAX=1 with both ports continuously requesting gives strict alternation: CPU, DMA, CPU, DMA, …

## Test plan
- Single CPU read, MEM_LAT=1:
  - Stimulus: memory returns 16'hBEEF, cpu_req high at T.
  - Required: mem_en high only at T+1 with mem_addr = cpu_addr; cpu_ready high only at T+3; cpu_rdata = 16'hBEEF; dma_rdata unchanged.
- DMA write, MEM_LAT=3:
  - Stimulus: addr 16'h3000, data 16'h1234.
  - Required: mem_en=1 and mem_we=1 for one cycle with that addr/data; dma_ready at T+5; both rdata registers unchanged.
- Contention, STARVE_MAX=4:
  - Stimulus: both ports request continuously, CPU re-requesting immediately.
  - Required: grant order CPU×4, DMA, CPU×4, DMA; starve_cnt returns to 0 after each DMA grant.
- Input changes after grant:
  - Stimulus: cpu_addr changed and cpu_req dropped during WAIT.
  - Required: mem_addr keeps the original value and cpu_ready still pulses once.
- Reset during WAIT, MEM_LAT=3:
  - Stimulus: reset asserted for one cycle.
  - Required: next cycle state IDLE, busy=0, no ready pulse, all outputs at reset values; a new request afterwards completes normally.
- Idle hold:
  - Stimulus: no requests for 20 cycles.
  - Required: mem_en=0, busy=0, ready outputs 0 throughout.
